host_frame_interface: RTL

- Device-side endpoint of the 32-bit host stream link; the host/bench is the writer of syndrome frames and the reader of result frames.
- Accepts a frame of test ID, sparse syndrome addresses and a 0xFFFFFFFF terminator, then unpacks it into the padded measurement vector for the decoder core.
- Waits for the core's clustering result, then emits a three-word result frame back to the host.

---
 rtl/host_frame_interface.sv | 136 +++++++++++++
 1 files changed

// File: rtl/host_frame_interface.sv
// Device-side host stream endpoint: unpacks a sparse syndrome frame into the padded
// measurement vector, hands it to the decoder core and returns a three-word result frame.
module host_frame_interface #(
  parameter int unsigned GRID_WIDTH_X      = 12,
  parameter int unsigned GRID_WIDTH_Z      = 4,
  parameter int unsigned GRID_WIDTH_U      = 5,
  parameter int unsigned ALIGNED_PER_ROUND = ((GRID_WIDTH_X * GRID_WIDTH_Z + 7) >> 3) << 3,
  parameter int unsigned MEAS_BITS         = ALIGNED_PER_ROUND * GRID_WIDTH_U
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          input_data,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic [31:0]          output_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [MEAS_BITS-1:0] measurements,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  input  logic                 result_valid,
  input  logic [15:0]          result_cycles,
  input  logic [7:0]           result_iterations,
  output logic [15:0]          syndrome_count,
  output logic                 addr_error,
  output logic                 busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDispatch,
    StWaitResult,
    StTxHdr,
    StTxId,
    StTxEnd
  } state_e;

  state_e         state;
  logic [31:0]    test_id;
  logic [7:0]     addr_u;
  logic [7:0]     addr_x;
  logic [7:0]     addr_z;
  logic           addr_in_range;
  logic [31:0]    bit_idx;
  logic [MEAS_BITS-1:0] set_mask;
  logic           is_term;
  logic           in_fire;

  assign addr_u  = input_data[23:16];
  assign addr_x  = input_data[15:8];
  assign addr_z  = input_data[7:0];
  assign is_term = (input_data == 32'hFFFF_FFFF);

  assign addr_in_range = (32'(addr_x) < GRID_WIDTH_X) && (32'(addr_z) < GRID_WIDTH_Z) &&
                         (32'(addr_u) < GRID_WIDTH_U);
  assign bit_idx  = 32'(addr_x) * GRID_WIDTH_Z + 32'(addr_z) + 32'(addr_u) * ALIGNED_PER_ROUND;
  // Only applied when in range, so the shift never lands in a padding bit.
  assign set_mask = {{(MEAS_BITS - 1){1'b0}}, 1'b1} << bit_idx;

  assign input_ready = (state == StIdle) || (state == StLoad);
  assign in_fire     = input_valid && input_ready;
  assign busy        = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      test_id        <= '0;
      measurements   <= '0;
      syndrome_count <= '0;
      addr_error     <= 1'b0;
      meas_valid     <= 1'b0;
      output_data    <= '0;
      output_valid   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          // Any word here is an ID, including the all-ones terminator pattern.
          if (in_fire) begin
            test_id        <= input_data;
            measurements   <= '0;
            syndrome_count <= '0;
            addr_error     <= 1'b0;
            state          <= StLoad;
          end
        end
        StLoad: begin
          if (in_fire) begin
            if (is_term) begin
              meas_valid <= 1'b1;
              state      <= StDispatch;
            end else begin
              if (addr_in_range) measurements <= measurements | set_mask;
              else               addr_error   <= 1'b1;
              if (syndrome_count != 16'hFFFF) syndrome_count <= syndrome_count + 16'd1;
            end
          end
        end
        StDispatch: begin
          if (meas_ready) begin
            meas_valid <= 1'b0;
            state      <= StWaitResult;
          end
        end
        StWaitResult: begin
          if (result_valid) begin
            output_data  <= {8'h00, result_iterations, result_cycles};
            output_valid <= 1'b1;
            state        <= StTxHdr;
          end
        end
        StTxHdr: begin
          if (output_ready) begin
            output_data <= test_id;
            state       <= StTxId;
          end
        end
        StTxId: begin
          if (output_ready) begin
            output_data <= 32'hFFFF_FFFF;
            state       <= StTxEnd;
          end
        end
        StTxEnd: begin
          if (output_ready) begin
            output_data  <= '0;
            output_valid <= 1'b0;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
